// File: rtl/snake_pkg.sv
// Shared snake-game types: board geometry, cell index, food FSM states, placement LFSR polynomial.
package snake_pkg;

  localparam int GRID_LOG2 = 3;
  localparam int CELLS     = 1 << (2 * GRID_LOG2);

  typedef logic [2*GRID_LOG2-1:0] cell_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    HIT,
    SEARCH,
    PLACED,
    FULL
  } fcu_state_t;

  // x^6 + x^5 + 1: feedback from the two most significant stages
  localparam cell_idx_t LFSR_TAPS = 6'b110000;

  function automatic cell_idx_t lfsr_next(input cell_idx_t v);
    return {v[4:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/food_lfsr.sv
// Free-running 6-bit Fibonacci LFSR used to pick the first candidate cell for food placement.
module food_lfsr
  import snake_pkg::*;
#(
  parameter cell_idx_t SEED = 6'h2D
) (
  input  logic      clk,
  input  logic      rst_n,
  output cell_idx_t value
);

  // A non-zero seed keeps the register out of the all-zero lock-up state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value <= SEED;
    else        value <= lfsr_next(value);
  end

endmodule

// File: rtl/food_collision_unit.sv
// Food placement and head-on-food detection; relocation scans one cell per cycle (1..64 cycles).
// Optional FOOD_SCORE_EN adds a saturating hit counter on the score output.
module food_collision_unit #(
  parameter int          GRID_LOG2 = 3,
  parameter logic [5:0]  LFSR_SEED = 6'h2D,
  parameter logic [5:0]  INIT_FOOD = 6'd36
) (
  input  logic                        clk_master,
  input  logic                        reset,
  input  logic                        set_collide,
  input  logic                        snake_increment,
  input  logic                        clk_food,
  input  logic [GRID_LOG2-1:0]        head_x,
  input  logic [GRID_LOG2-1:0]        head_y,
  input  logic [snake_pkg::CELLS-1:0] body_map,
  output logic [GRID_LOG2-1:0]        food_x,
  output logic [GRID_LOG2-1:0]        food_y,
  output logic                        food_valid,
  output logic                        food_collision,
  output logic                        food_collision_replace,
`ifdef FOOD_SCORE_EN
  output logic [7:0]                  score,
`endif
  output logic                        board_full
);
  import snake_pkg::*;

  fcu_state_t state, state_nxt;
  cell_idx_t  food, food_nxt;
  cell_idx_t  cand, cand_nxt;
  cell_idx_t  tries, tries_nxt;
  cell_idx_t  lfsr;
  logic       valid_nxt, coll_nxt, repl_nxt, full_nxt;

  food_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk_master),
    .rst_n (reset),
    .value (lfsr)
  );

  always_comb begin
    state_nxt = state;
    food_nxt  = food;
    cand_nxt  = cand;
    tries_nxt = tries;
    valid_nxt = food_valid;
    coll_nxt  = food_collision;
    repl_nxt  = food_collision_replace;
    full_nxt  = board_full;
    case (state)
      IDLE: begin
        if (set_collide && ({head_y, head_x} == food)) begin
          state_nxt = HIT;
          coll_nxt  = 1'b1;
        end
      end
      HIT: begin
        if (snake_increment) begin
          state_nxt = SEARCH;
          coll_nxt  = 1'b0;
          valid_nxt = 1'b0;
          cand_nxt  = lfsr;
          tries_nxt = '0;
        end
      end
      SEARCH: begin
        // The old food cell is excluded so the new food always moves.
        if (!body_map[cand] && (cand != food)) begin
          state_nxt = PLACED;
          food_nxt  = cand;
          valid_nxt = 1'b1;
          repl_nxt  = 1'b1;
        end else if (tries == 6'd63) begin
          state_nxt = FULL;
          full_nxt  = 1'b1;
        end else begin
          cand_nxt  = cand + 6'd1;
          tries_nxt = tries + 6'd1;
        end
      end
      PLACED: begin
        if (clk_food) begin
          state_nxt = IDLE;
          repl_nxt  = 1'b0;
        end
      end
      FULL: begin
        state_nxt = FULL;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_master or negedge reset) begin
    if (!reset) begin
      state                  <= IDLE;
      food                   <= INIT_FOOD;
      cand                   <= '0;
      tries                  <= '0;
      food_valid             <= 1'b1;
      food_collision         <= 1'b0;
      food_collision_replace <= 1'b0;
      board_full             <= 1'b0;
    end else begin
      state                  <= state_nxt;
      food                   <= food_nxt;
      cand                   <= cand_nxt;
      tries                  <= tries_nxt;
      food_valid             <= valid_nxt;
      food_collision         <= coll_nxt;
      food_collision_replace <= repl_nxt;
      board_full             <= full_nxt;
    end
  end

  assign food_x = food[2:0];
  assign food_y = food[5:3];

`ifdef FOOD_SCORE_EN
  always_ff @(posedge clk_master or negedge reset) begin
    if (!reset) begin
      score <= 8'd0;
    end else if ((state == IDLE) && (state_nxt == HIT) && (score != 8'hFF)) begin
      score <= score + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_food_collision_unit.sv
// Randomized bench for food_collision_unit against a cycle-counted LFSR table and a cell-scan placement model.
module tb_food_collision_unit;

  logic        clk_master = 1'b0;
  logic        reset = 1'b0;
  logic        set_collide = 1'b0;
  logic        snake_increment = 1'b0;
  logic        clk_food = 1'b0;
  logic [2:0]  head_x = '0;
  logic [2:0]  head_y = '0;
  logic [63:0] body_map = '0;
  logic [2:0]  food_x, food_y;
  logic        food_valid, food_collision, food_collision_replace, board_full;
`ifdef FOOD_SCORE_EN
  logic [7:0]  score;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] seq [0:62];
  int         cyc;
  logic [5:0] m_lfsr;
  logic [5:0] m_food = 6'd36;

  food_collision_unit #(.GRID_LOG2(3), .LFSR_SEED(6'h2D), .INIT_FOOD(6'd36)) dut (
    .clk_master             (clk_master),
    .reset                  (reset),
    .set_collide            (set_collide),
    .snake_increment        (snake_increment),
    .clk_food               (clk_food),
    .head_x                 (head_x),
    .head_y                 (head_y),
    .body_map               (body_map),
    .food_x                 (food_x),
    .food_y                 (food_y),
    .food_valid             (food_valid),
    .food_collision         (food_collision),
    .food_collision_replace (food_collision_replace),
`ifdef FOOD_SCORE_EN
    .score                  (score),
`endif
    .board_full             (board_full)
  );

  always #5 clk_master = ~clk_master;

  // The placement LFSR has period 63, so its value is a table lookup on cycles since reset.
  always @(posedge clk_master or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end
  assign m_lfsr = seq[cyc % 63];

  function automatic void build_seq();
    int s;
    s = 'h2D;
    for (int k = 0; k < 63; k++) begin
      seq[k] = 6'(s);
      s = ((s * 2) + (((s / 32) + (s / 16)) % 2)) % 64;
    end
  endfunction

  // First free cell scanning upward from start (wrapping), never the old food cell.
  function automatic void ref_place(input logic [5:0] start, input logic [63:0] body,
                                    input logic [5:0] old, output int idx, output int lat);
    idx = -1;
    lat = 64;
    for (int i = 0; i < 64; i++) begin
      int c;
      c = (int'(start) + i) % 64;
      if (!body[c] && (c != int'(old))) begin
        idx = c;
        lat = i + 1;
        return;
      end
    end
  endfunction

  task automatic do_hit();
    head_x = m_food[2:0];
    head_y = m_food[5:3];
    set_collide = 1'b1;
    @(negedge clk_master);
    set_collide = 1'b0;
  endtask

  task automatic enter_search(input logic [5:0] target, input logic [63:0] body, output bit found);
    found = 1'b0;
    body_map = body;
    for (int i = 0; i < 80 && !found; i++) begin
      if (m_lfsr == target) found = 1'b1;
      else @(negedge clk_master);
    end
    if (found) begin
      snake_increment = 1'b1;
      @(negedge clk_master);
      snake_increment = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk_master);
    reset = 1'b1;
    m_food = 6'd36;
    @(negedge clk_master);
    vectors++; if ({food_y, food_x} !== 6'd36) begin miscompares++; $display("FAIL reset_food: got (%0d,%0d) expected (4,4)", food_x, food_y); end
    vectors++; if (food_valid !== 1'b1) begin miscompares++; $display("FAIL reset_valid: got %b expected 1", food_valid); end
    vectors++; if (food_collision !== 1'b0) begin miscompares++; $display("FAIL reset_coll: got %b expected 0", food_collision); end
    vectors++; if (food_collision_replace !== 1'b0) begin miscompares++; $display("FAIL reset_repl: got %b expected 0", food_collision_replace); end
    vectors++; if (board_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", board_full); end
  endtask

  task automatic test_hit_and_place();
    bit found;
    head_x = m_food[2:0] ^ 3'd1;
    head_y = m_food[5:3];
    set_collide = 1'b1;
    @(negedge clk_master);
    set_collide = 1'b0;
    vectors++; if (food_collision !== 1'b0) begin miscompares++; $display("FAIL miss_coll: got %b expected 0", food_collision); end
    do_hit();
    vectors++; if (food_collision !== 1'b1) begin miscompares++; $display("FAIL hit_coll: got %b expected 1", food_collision); end
    for (int i = 0; i < 20; i++) begin
      set_collide = (i % 3 == 0);
      @(negedge clk_master);
      vectors++; if (food_collision !== 1'b1 || food_valid !== 1'b1) begin miscompares++; $display("FAIL hit_hold[%0d]: coll=%b valid=%b expected 1,1", i, food_collision, food_valid); end
    end
    set_collide = 1'b0;
    enter_search(6'h10, 64'h0, found);
    vectors++; if (!found) begin miscompares++; $display("FAIL lfsr_wait_10: got timeout expected lfsr 0x10"); end
    vectors++; if (food_collision !== 1'b0 || food_valid !== 1'b0) begin miscompares++; $display("FAIL search_entry: coll=%b valid=%b expected 0,0", food_collision, food_valid); end
    @(negedge clk_master);
    vectors++; if (food_x !== 3'd0 || food_y !== 3'd2 || food_valid !== 1'b1) begin miscompares++; $display("FAIL place_10: got (%0d,%0d) valid=%b expected (0,2) valid=1", food_x, food_y, food_valid); end
    m_food = 6'h10;
    head_x = m_food[2:0];
    head_y = m_food[5:3];
    for (int i = 0; i < 5; i++) begin
      set_collide = (i % 2 == 0);
      snake_increment = (i % 2 == 1);
      @(negedge clk_master);
      vectors++; if (food_collision_replace !== 1'b1 || food_collision !== 1'b0) begin miscompares++; $display("FAIL placed_hold[%0d]: repl=%b coll=%b expected 1,0", i, food_collision_replace, food_collision); end
    end
    set_collide = 1'b0;
    snake_increment = 1'b0;
    clk_food = 1'b1;
    @(negedge clk_master);
    clk_food = 1'b0;
    vectors++; if (food_collision_replace !== 1'b0) begin miscompares++; $display("FAIL ack_repl: got %b expected 0", food_collision_replace); end
  endtask

  task automatic test_wrap();
    bit found;
    do_hit();
    vectors++; if (food_collision !== 1'b1) begin miscompares++; $display("FAIL wrap_hit: got %b expected 1", food_collision); end
    enter_search(6'h3E, ~(64'h1 << 5), found);
    vectors++; if (!found) begin miscompares++; $display("FAIL lfsr_wait_3e: got timeout expected lfsr 0x3E"); end
    repeat (7) @(negedge clk_master);
    vectors++; if (food_collision_replace !== 1'b0) begin miscompares++; $display("FAIL wrap_early: repl=%b expected 0 after 7 cycles", food_collision_replace); end
    @(negedge clk_master);
    vectors++; if (food_x !== 3'd5 || food_y !== 3'd0 || food_collision_replace !== 1'b1) begin miscompares++; $display("FAIL wrap_place: got (%0d,%0d) repl=%b expected (5,0) repl=1", food_x, food_y, food_collision_replace); end
    m_food = 6'd5;
    clk_food = 1'b1;
    @(negedge clk_master);
    clk_food = 1'b0;
  endtask

  task automatic test_simultaneous();
    bit found;
    int idx, lat;
    logic [5:0] tgt;
    head_x = m_food[2:0];
    head_y = m_food[5:3];
    set_collide = 1'b1;
    snake_increment = 1'b1;
    @(negedge clk_master);
    set_collide = 1'b0;
    snake_increment = 1'b0;
    repeat (3) @(negedge clk_master);
    vectors++; if (food_collision !== 1'b1 || food_valid !== 1'b1) begin miscompares++; $display("FAIL simul_hit: coll=%b valid=%b expected 1,1", food_collision, food_valid); end
    tgt = 6'($urandom_range(1, 63));
    enter_search(tgt, 64'h0, found);
    vectors++; if (!found) begin miscompares++; $display("FAIL lfsr_wait_simul: got timeout expected lfsr %0h", tgt); end
    ref_place(tgt, 64'h0, m_food, idx, lat);
    repeat (lat) @(negedge clk_master);
    vectors++; if (int'({food_y, food_x}) != idx || food_collision_replace !== 1'b1) begin miscompares++; $display("FAIL simul_place: got cell %0d repl=%b expected cell %0d repl=1", {food_y, food_x}, food_collision_replace, idx); end
    m_food = 6'(idx);
    clk_food = 1'b1;
    @(negedge clk_master);
    clk_food = 1'b0;
  endtask

  task automatic test_back_to_back_random();
    for (int it = 0; it < 12; it++) begin
      logic [63:0] body;
      logic [5:0]  tgt, hole;
      int          idx, lat;
      bit          found;
      body = {$urandom, $urandom} | {$urandom, $urandom};
      if (it % 3 == 0) body = body | {$urandom, $urandom};
      hole = 6'($urandom_range(0, 63));
      if (hole == m_food) hole = hole + 6'd1;
      body[hole] = 1'b0;
      body[m_food] = 1'($urandom_range(0, 1));
      tgt = 6'($urandom_range(1, 63));
      do_hit();
      vectors++; if (food_collision !== 1'b1) begin miscompares++; $display("FAIL rnd_hit[%0d]: got %b expected 1", it, food_collision); end
      enter_search(tgt, body, found);
      vectors++; if (!found) begin miscompares++; $display("FAIL rnd_lfsr_wait[%0d]: got timeout expected lfsr %0h", it, tgt); end
      ref_place(tgt, body, m_food, idx, lat);
      if (lat > 1) begin
        repeat (lat - 1) @(negedge clk_master);
        vectors++; if (food_collision_replace !== 1'b0 || food_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_early[%0d]: repl=%b valid=%b expected 0,0 at cycle %0d", it, food_collision_replace, food_valid, lat - 1); end
      end
      @(negedge clk_master);
      vectors++; if (int'({food_y, food_x}) != idx || food_collision_replace !== 1'b1 || food_valid !== 1'b1) begin miscompares++; $display("FAIL rnd_place[%0d]: got cell %0d repl=%b valid=%b expected cell %0d repl=1 valid=1", it, {food_y, food_x}, food_collision_replace, food_valid, idx); end
      m_food = 6'(idx);
      clk_food = 1'b1;
      @(negedge clk_master);
      clk_food = 1'b0;
      vectors++; if (food_collision_replace !== 1'b0) begin miscompares++; $display("FAIL rnd_ack[%0d]: got %b expected 0", it, food_collision_replace); end
    end
  endtask

`ifdef FOOD_SCORE_EN
  task automatic test_score();
    test_reset();
    vectors++; if (score !== 8'd0) begin miscompares++; $display("FAIL score_reset: got %0d expected 0", score); end
    for (int n = 0; n < 3; n++) begin
      bit found;
      int idx, lat;
      logic [5:0] tgt;
      do_hit();
      tgt = 6'($urandom_range(1, 63));
      enter_search(tgt, 64'h0, found);
      ref_place(tgt, 64'h0, m_food, idx, lat);
      repeat (lat) @(negedge clk_master);
      m_food = 6'(idx);
      clk_food = 1'b1;
      @(negedge clk_master);
      clk_food = 1'b0;
    end
    vectors++; if (score !== 8'd3) begin miscompares++; $display("FAIL score_three: got %0d expected 3", score); end
    reset = 1'b0;
    #1;
    vectors++; if (score !== 8'd0) begin miscompares++; $display("FAIL score_clear: got %0d expected 0", score); end
    @(negedge clk_master);
    reset = 1'b1;
    m_food = 6'd36;
  endtask
`endif

  task automatic test_full();
    bit found;
    logic [5:0] tgt;
    do_hit();
    vectors++; if (food_collision !== 1'b1) begin miscompares++; $display("FAIL full_hit: got %b expected 1", food_collision); end
    tgt = 6'($urandom_range(1, 63));
    enter_search(tgt, '1, found);
    vectors++; if (!found) begin miscompares++; $display("FAIL full_lfsr_wait: got timeout expected lfsr %0h", tgt); end
    repeat (63) @(negedge clk_master);
    vectors++; if (board_full !== 1'b0) begin miscompares++; $display("FAIL full_early: got %b expected 0 after 63 cycles", board_full); end
    @(negedge clk_master);
    vectors++; if (board_full !== 1'b1 || food_valid !== 1'b0) begin miscompares++; $display("FAIL full_set: full=%b valid=%b expected 1,0", board_full, food_valid); end
    head_x = m_food[2:0];
    head_y = m_food[5:3];
    body_map = '0;
    set_collide = 1'b1;
    snake_increment = 1'b1;
    clk_food = 1'b1;
    repeat (3) @(negedge clk_master);
    set_collide = 1'b0;
    snake_increment = 1'b0;
    clk_food = 1'b0;
    vectors++; if (board_full !== 1'b1 || food_valid !== 1'b0 || food_collision !== 1'b0 || food_collision_replace !== 1'b0) begin miscompares++; $display("FAIL full_sticky: full=%b valid=%b coll=%b repl=%b expected 1,0,0,0", board_full, food_valid, food_collision, food_collision_replace); end
    reset = 1'b0;
    @(negedge clk_master);
    vectors++; if (board_full !== 1'b0 || food_valid !== 1'b1 || {food_y, food_x} !== 6'd36) begin miscompares++; $display("FAIL full_reset: full=%b valid=%b cell=%0d expected 0,1,36", board_full, food_valid, {food_y, food_x}); end
    reset = 1'b1;
    m_food = 6'd36;
  endtask

  task automatic test_reset_mid_search();
    bit found;
    do_hit();
    enter_search(6'($urandom_range(1, 63)), '1, found);
    vectors++; if (!found) begin miscompares++; $display("FAIL mid_lfsr_wait: got timeout expected lfsr match"); end
    repeat (10) @(negedge clk_master);
    #2;
    reset = 1'b0;
    #1;
    vectors++; if ({food_y, food_x} !== 6'd36 || food_valid !== 1'b1 || food_collision !== 1'b0 || food_collision_replace !== 1'b0 || board_full !== 1'b0) begin miscompares++; $display("FAIL mid_reset: cell=%0d valid=%b coll=%b repl=%b full=%b expected 36,1,0,0,0", {food_y, food_x}, food_valid, food_collision, food_collision_replace, board_full); end
    @(negedge clk_master);
    reset = 1'b1;
    m_food = 6'd36;
    body_map = '0;
    do_hit();
    vectors++; if (food_collision !== 1'b1) begin miscompares++; $display("FAIL post_reset_hit: got %b expected 1", food_collision); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_seq();
    test_reset();
    test_hit_and_place();
    test_wrap();
    test_simultaneous();
    test_back_to_back_random();
`ifdef FOOD_SCORE_EN
    test_score();
`endif
    test_full();
    test_reset_mid_search();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
